// File: rtl/karatsuba_job_sequencer_pkg.sv
// Shared definitions for the Karatsuba job sequencer: FSM state encoding
// and default multiplier latency.
package karatsuba_job_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_CLEAR   = 4'b0010,
        ST_RUN     = 4'b0100,
        ST_CAPTURE = 4'b1000
    } seq_state_e;

    localparam int MUL_LATENCY_DEFAULT = 6;

endpackage

// File: rtl/kara_operand_fifo.sv
// Synchronous operand FIFO with asynchronous reset; dout shows the head entry
// so it is valid in the same cycle pop is asserted.
module kara_operand_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign dout      = mem_q[rd_ptr_q];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/karatsuba_job_sequencer.sv
// Feeds operand pairs one at a time to the iterative Karatsuba multiplier
// (clear, fixed-length run, capture) and holds each product in an output slot.
module karatsuba_job_sequencer
    import karatsuba_job_sequencer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        mul_rst,
    output logic        mul_enable,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_c,
    output logic        busy
);
    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    seq_state_e        state_q, state_d;
    logic [63:0]       op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [63:0]       out_c_q, out_c_d;

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [63:0]       fifo_dout_s;
    logic              push_s;
    logic              pop_s;
    logic              slot_free_s;

    assign in_ready    = ~fifo_full_s;
    assign push_s      = in_valid & ~fifo_full_s;
    assign slot_free_s = ~out_valid_q | out_ready;

    kara_operand_fifo #(
        .W     (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({in_a, in_b}),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Job sequencing and output-slot next-state
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_c_d     = out_c_q;
        pop_s       = 1'b0;

        if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    op_d    = fifo_dout_s;
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MUL_LATENCY - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CAPTURE: begin
                // enable is low here, so mul_c holds until the slot frees
                if (slot_free_s) begin
                    out_c_d     = mul_c;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, operand, counter and output slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
        end
    end

    assign mul_rst    = rst | (state_q == ST_CLEAR);
    assign mul_enable = (state_q == ST_RUN);
    assign mul_a      = op_q[63:32];
    assign mul_b      = op_q[31:0];
    assign out_valid  = out_valid_q;
    assign out_c      = out_c_q;
    assign busy       = (state_q != ST_IDLE) | ~fifo_empty_s | out_valid_q;

endmodule
